// File: rtl/conv2d_if.sv
// Operand-load, control and result-stream bundle for conv2d_engine.
// Widths are derived from N/K/DW exactly as the engine derives them.
interface conv2d_if #(
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int DW = 8
);
  localparam int M   = N - K + 1;
  localparam int AW  = 2*DW + $clog2(K*K);
  localparam int AAW = (N*N > 1) ? $clog2(N*N) : 1;
  localparam int BAW = (K*K > 1) ? $clog2(K*K) : 1;
  localparam int OIW = (M*M > 1) ? $clog2(M*M) : 1;

  logic           run;
  logic           mode;
  logic           a_we;
  logic [AAW-1:0] a_addr;
  logic [DW-1:0]  a_data;
  logic           b_we;
  logic [BAW-1:0] b_addr;
  logic [DW-1:0]  b_data;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [AW-1:0]  out_data;
  logic [OIW-1:0] out_index;
  logic           done;

  modport slave (
    input  run, mode, a_we, a_addr, a_data, b_we, b_addr, b_data, out_ready,
    output busy, out_valid, out_data, out_index, done
  );

  modport master (
    output run, mode, a_we, a_addr, a_data, b_we, b_addr, b_data, out_ready,
    input  busy, out_valid, out_data, out_index, done
  );
endinterface

// File: rtl/conv2d_engine.sv
// Sequential N x N by K x K correlation/convolution engine: one MAC per cycle,
// results streamed in raster order over a valid/ready handshake.
module conv2d_engine #(
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int DW = 8
) (
  input logic       clk,
  input logic       reset,
  conv2d_if.slave   bus
);
  localparam int M   = N - K + 1;
  localparam int AW  = 2*DW + $clog2(K*K);
  localparam int AAW = (N*N > 1) ? $clog2(N*N) : 1;
  localparam int BAW = (K*K > 1) ? $clog2(K*K) : 1;
  localparam int OIW = (M*M > 1) ? $clog2(M*M) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  r_q, r_d, c_q, c_d;
  logic [KW-1:0]  i_q, i_d, j_q, j_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  out_data_q, out_data_d;
  logic [OIW-1:0] out_index_q, out_index_d;
  logic           done_q, done_d;

  logic [DW-1:0]  amem [N*N];
  logic [DW-1:0]  bmem [K*K];

  // Operand memories are not reset; loads are only accepted while idle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (bus.a_we && (int'(bus.a_addr) < N*N)) amem[bus.a_addr] <= bus.a_data;
      if (bus.b_we && (int'(bus.b_addr) < K*K)) bmem[bus.b_addr] <= bus.b_data;
    end
  end

  logic [AAW-1:0]  fa;
  logic [BAW-1:0]  wa;
  logic [2*DW-1:0] prod;

  // Convolution reads the kernel point-reflected through its centre.
  always_comb begin
    fa = AAW'((int'(r_q) + int'(i_q)) * N + int'(c_q) + int'(j_q));
    if (mode_q) wa = BAW'((K - 1 - int'(i_q)) * K + (K - 1 - int'(j_q)));
    else        wa = BAW'(int'(i_q) * K + int'(j_q));
    prod = {{DW{1'b0}}, amem[fa]} * {{DW{1'b0}}, bmem[wa]};
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    r_d         = r_q;
    c_d         = c_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = CALC;
          mode_d  = bus.mode;
          r_d     = '0;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      CALC: begin
        acc_d = acc_q + AW'(prod);
        if (j_q == KW'(K - 1)) begin
          j_d = '0;
          if (i_q == KW'(K - 1)) begin
            i_d         = '0;
            state_d     = EMIT;
            out_data_d  = acc_d;
            out_index_d = OIW'(int'(r_q) * M + int'(c_q));
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (r_q == CW'(M - 1) && c_q == CW'(M - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            if (c_q == CW'(M - 1)) begin
              c_d = '0;
              r_d = r_q + CW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      r_q         <= r_d;
      c_q         <= c_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine (N=4, K=3, DW=8) with hand-computed results.
module tb_conv2d_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  conv2d_if #(.N(4), .K(3), .DW(8)) bus ();

  conv2d_engine #(.N(4), .K(3), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wa(input int addr, input int data);
    bus.a_we = 1'b1; bus.a_addr = 4'(addr); bus.a_data = 8'(data);
    @(negedge clk);
    bus.a_we = 1'b0;
  endtask

  task automatic wb(input int addr, input int data);
    bus.b_we = 1'b1; bus.b_addr = 4'(addr); bus.b_data = 8'(data);
    @(negedge clk);
    bus.b_we = 1'b0;
  endtask

  // Runs one job from a negedge; stall holds out_ready low on the first result,
  // disturb injects a run pulse and a feature write while busy.
  task automatic run_job(input string tag, input bit m, input int e0, input int e1,
                         input int e2, input int e3, input int exp_busy,
                         input int stall, input bit disturb);
    int e[4];
    int bcnt, nout, stalled, cyc;
    bit got_done, seen_valid;
    e = '{e0, e1, e2, e3};
    bcnt = 0; nout = 0; stalled = 0; cyc = 0; got_done = 0; seen_valid = 0;
    bus.out_ready = 1'b1;
    bus.run = 1'b1; bus.mode = m;
    @(negedge clk);
    bus.run = 1'b0; bus.mode = 1'b0;
    while (!got_done && cyc < 300) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got_done = 1;
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        chk({tag, "_busy_cycles"}, bcnt, exp_busy);
      end else if (bus.out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          chk({tag, "_first_valid_lat"}, bcnt, 10);
        end
        if (nout == 0 && stalled < stall) begin
          bus.out_ready = 1'b0;
          chk({tag, "_hold_data"}, 32'(bus.out_data), e[0]);
          chk({tag, "_hold_index"}, 32'(bus.out_index), 0);
          stalled++;
        end else begin
          bus.out_ready = 1'b1;
          if (nout < 4) begin
            chk({tag, "_data"}, 32'(bus.out_data), e[nout]);
            chk({tag, "_index"}, 32'(bus.out_index), nout);
          end
          nout++;
        end
      end
      if (disturb && bcnt == 3) begin
        bus.run = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd0; bus.a_data = 8'd200;
      end else begin
        bus.run = 1'b0; bus.a_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.run = 1'b0; bus.a_we = 1'b0; bus.out_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(got_done), 1);
    chk({tag, "_num_outputs"}, nout, 4);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 0);
  endtask

  initial begin
    bus.run = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    bus.a_we = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_we = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_index", 32'(bus.out_index), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    @(negedge clk);

    // Window sum: a = 1..16, b all ones
    for (int i = 0; i < 16; i++) wa(i, i + 1);
    for (int i = 0; i < 9; i++) wb(i, 1);
    run_job("winsum", 1'b0, 54, 63, 90, 99, 40, 0, 1'b0);

    run_job("backpr", 1'b0, 54, 63, 90, 99, 45, 5, 1'b0);

    run_job("guard", 1'b0, 54, 63, 90, 99, 40, 0, 1'b1);
    run_job("guard_after", 1'b0, 54, 63, 90, 99, 40, 0, 1'b0);

    // Reset during the second window's CALC phase
    bus.run = 1'b1; bus.mode = 1'b0;
    @(negedge clk);
    bus.run = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job("post_rst", 1'b0, 54, 63, 90, 99, 40, 0, 1'b0);

    // Single-tap kernel exposes correlation vs convolution indexing
    wb(0, 1);
    for (int i = 1; i < 9; i++) wb(i, 0);
    run_job("flip_m0", 1'b0, 1, 2, 5, 6, 40, 0, 1'b0);
    run_job("flip_m1", 1'b1, 11, 12, 15, 16, 40, 0, 1'b0);

    for (int i = 0; i < 16; i++) wa(i, 255);
    for (int i = 0; i < 9; i++) wb(i, 255);
    run_job("width", 1'b0, 585225, 585225, 585225, 585225, 40, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
